// File: rtl/prog_run_ctrl_if.sv
// Dump request port of the run controller: one word request per valid/ready transfer.
// sel chooses register file (0) or data memory (1); addr is the word address.
interface prog_run_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              valid;
  logic              ready;
  logic              sel;
  logic [ADDR_W-1:0] addr;

  modport master (output valid, output sel, output addr, input ready);
  modport slave  (input valid, input sel, input addr, output ready);
endinterface

// File: rtl/prog_run_ctrl.sv
// Run controller for the single-cycle MIPS top: runs the CPU until the PC passes the program
// end or the cycle budget expires, freezes it, then dumps register file and data memory.
module prog_run_ctrl #(
  parameter int unsigned NUM_INSTR  = 26,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned MAX_CYCLES = 4096,
  parameter int unsigned RF_DEPTH   = 32,
  parameter int unsigned DM_DEPTH   = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_W-1:0]      pc,
  output logic                 cpu_en,
  prog_run_ctrl_if.master      dump,
  output logic                 done,
  output logic                 timeout,
  output logic [31:0]          cycle_count
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRun    = 3'd1;
  localparam logic [2:0] StDrain  = 3'd2;
  localparam logic [2:0] StDumpRf = 3'd3;
  localparam logic [2:0] StDumpDm = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  localparam logic [PC_W-1:0]   EndLimit = PC_W'(NUM_INSTR * 4);
  localparam logic [31:0]       MaxCount = 32'(MAX_CYCLES);
  localparam logic [ADDR_W-1:0] RfLast   = ADDR_W'(RF_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DmLast   = ADDR_W'(DM_DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       count_q, count_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       count_inc;

  assign count_inc = count_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    case (state_q)
      StIdle, StDone: begin
        addr_d = '0;
        if (start) begin
          state_d   = StRun;
          count_d   = '0;
          timeout_d = 1'b0;
        end
      end
      StRun: begin
        count_d = count_inc;
        // PC end condition takes priority over the budget on the same edge
        if (pc > EndLimit) begin
          state_d = StDrain;
        end else if (count_inc == MaxCount) begin
          state_d   = StDrain;
          timeout_d = 1'b1;
        end
      end
      StDrain: begin
        state_d = StDumpRf;
        addr_d  = '0;
      end
      StDumpRf: begin
        if (dump.ready) begin
          if (addr_q == RfLast) begin
            state_d = StDumpDm;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDumpDm: begin
        if (dump.ready) begin
          if (addr_q == DmLast) begin
            state_d = StDone;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode registered state only; no path from pc or ready.
  assign cpu_en      = (state_q == StRun);
  assign dump.valid  = (state_q == StDumpRf) || (state_q == StDumpDm);
  assign dump.sel    = (state_q == StDumpDm);
  assign dump.addr   = addr_q;
  assign done        = (state_q == StDone);
  assign timeout     = timeout_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: table of run scenarios plus randomized runs against a rule-level
// model of run length, timeout and the ordered dump sequence.
module tb_prog_run_ctrl;

  localparam int unsigned MaxCyc = 64;
  localparam int unsigned Limit  = 104;
  localparam int unsigned RfD    = 32;
  localparam int unsigned DmD    = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic        cpu_en;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  prog_run_ctrl_if #(.ADDR_W(8)) dif ();

  prog_run_ctrl #(
    .NUM_INSTR (26),
    .PC_W      (32),
    .MAX_CYCLES(MaxCyc),
    .RF_DEPTH  (RfD),
    .DM_DEPTH  (DmD),
    .ADDR_W    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .dump       (dif),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned pc0;
    int unsigned step;
    int unsigned jump_k;
    logic [31:0] jump_pc;
    bit          rand_ready;
    bit          hold_start;
    int unsigned exp_cycles;
    bit          exp_timeout;
  } run_t;

  typedef struct packed {
    logic       sel;
    logic [7:0] addr;
  } xfer_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  function automatic run_t mk(input int unsigned pc0, input int unsigned step,
                              input int unsigned jk, input logic [31:0] jpc, input bit rr,
                              input bit hs, input int unsigned ec, input bit et);
    run_t r;
    r.pc0 = pc0; r.step = step; r.jump_k = jk; r.jump_pc = jpc;
    r.rand_ready = rr; r.hold_start = hs; r.exp_cycles = ec; r.exp_timeout = et;
    return r;
  endfunction

  // PC presented during the k-th RUN cycle of a scenario.
  function automatic logic [31:0] pc_at(input run_t r, input int unsigned k);
    if (k >= r.jump_k) return r.jump_pc;
    return 32'(r.pc0 + r.step * k);
  endfunction

  // Run ends on the first cycle whose PC exceeds the limit, else after MaxCyc cycles.
  task automatic model(input run_t r, output int unsigned cyc, output bit to);
    cyc = MaxCyc;
    to  = 1'b1;
    for (int unsigned k = 0; k < MaxCyc; k++) begin
      if (pc_at(r, k) > 32'(Limit)) begin
        cyc = k + 1;
        to  = 1'b0;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_cpu_en"}, cpu_en, 1'b0);
    chk1({tag, "_valid"}, dif.valid, 1'b0);
    chk1({tag, "_sel"}, dif.sel, 1'b0);
    chk({tag, "_addr"}, 32'(dif.addr), 32'd0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_cycle_count"}, cycle_count, 32'd0);
  endtask

  task automatic do_run(input run_t r, input int abort_addr);
    int unsigned k;
    int unsigned cyc;
    xfer_t       q[$];
    xfer_t       f;
    bit          rdy;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!r.hold_start) start = 1'b0;
    chk1("start_cpu_en", cpu_en, 1'b1);
    chk("start_cycle_count", cycle_count, 32'd0);
    chk1("start_done", done, 1'b0);
    chk1("start_timeout", timeout, 1'b0);
    k = 0;
    while (cpu_en === 1'b1 && k < 200) begin
      pc = pc_at(r, k);
      k++;
      @(negedge clk);
    end
    chk("run_cycles", k, r.exp_cycles);
    chk("end_cycle_count", cycle_count, r.exp_cycles);
    chk1("end_timeout", timeout, r.exp_timeout);
    chk1("drain_valid", dif.valid, 1'b0);
    @(negedge clk);
    chk1("dump_valid_rise", dif.valid, 1'b1);
    q = {};
    for (int a = 0; a < int'(RfD); a++) q.push_back('{sel: 1'b0, addr: 8'(a)});
    for (int a = 0; a < int'(DmD); a++) q.push_back('{sel: 1'b1, addr: 8'(a)});
    cyc = 0;
    while (q.size() > 0 && cyc < 3000) begin
      f = q[0];
      if (abort_addr >= 0 && f.sel && int'(f.addr) == abort_addr) begin
        chk("pre_abort_addr", 32'(dif.addr), 32'(abort_addr));
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        dif.ready = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset_idle");
        return;
      end
      chk1("dump_valid", dif.valid, 1'b1);
      chk1("dump_sel", dif.sel, f.sel);
      chk("dump_addr", 32'(dif.addr), 32'(f.addr));
      chk1("dump_done_low", done, 1'b0);
      rdy = r.rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      dif.ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) void'(q.pop_front());
    end
    dif.ready = 1'b0;
    chk("dump_remaining", 32'(q.size()), 32'd0);
    if (!r.rand_ready) chk("dump_cycles", cyc, RfD + DmD);
    chk1("done_rise", done, 1'b1);
    chk1("done_valid_low", dif.valid, 1'b0);
    chk1("done_cpu_en_low", cpu_en, 1'b0);
    chk("done_cycle_count", cycle_count, r.exp_cycles);
    chk1("done_timeout", timeout, r.exp_timeout);
    start = 1'b0;
    @(negedge clk);
    chk1("done_hold", done, 1'b1);
    chk("done_hold_count", cycle_count, r.exp_cycles);
  endtask

  run_t tbl[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    run_t        r;
    int unsigned ec;
    bit          et;

    tbl[0]  = mk(0,   4, 1000, 32'd0,        1'b0, 1'b0, 28, 1'b0); // normal program
    tbl[1]  = mk(0,   0, 1000, 32'd0,        1'b0, 1'b0, 64, 1'b1); // stuck pc -> budget
    tbl[2]  = mk(104, 0, 1000, 32'd0,        1'b0, 1'b0, 64, 1'b1); // 104 is not past end
    tbl[3]  = mk(105, 0, 1000, 32'd0,        1'b0, 1'b0, 1,  1'b0); // 105 ends at once
    tbl[4]  = mk(100, 1, 1000, 32'd0,        1'b0, 1'b0, 6,  1'b0);
    tbl[5]  = mk(0,   2, 1000, 32'd0,        1'b0, 1'b0, 54, 1'b0);
    tbl[6]  = mk(0,   0, 0,    32'hFFFF_FFFF, 1'b0, 1'b0, 1,  1'b0); // unsigned compare
    tbl[7]  = mk(0,   0, 63,   32'd105,      1'b0, 1'b0, 64, 1'b0); // end and budget together
    tbl[8]  = mk(0,   0, 62,   32'd105,      1'b0, 1'b0, 63, 1'b0);
    tbl[9]  = mk(0,   4, 1000, 32'd0,        1'b1, 1'b1, 28, 1'b0); // start held, backpressure
    tbl[10] = mk(0,   0, 1000, 32'd0,        1'b1, 1'b0, 64, 1'b1);

    reset     = 1'b1;
    start     = 1'b0;
    pc        = '0;
    dif.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("idle");

    foreach (tbl[i]) do_run(tbl[i], -1);

    // Abandon a timed-out run mid data-memory dump, then rerun from idle.
    do_run(tbl[1], 100);
    do_run(tbl[0], -1);

    for (int n = 0; n < 8; n++) begin
      r = mk($urandom_range(110, 0), $urandom_range(3, 0), $urandom_range(70, 0),
             32'($urandom_range(120, 90)), 1'b1, 1'($urandom_range(1, 0)), 0, 1'b0);
      model(r, ec, et);
      r.exp_cycles  = ec;
      r.exp_timeout = et;
      do_run(r, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
